// File: rtl/int2fp_if.sv
// rtl/int2fp_if.sv - start/operand/result handshake bundle for the int2fp converter
interface int2fp_if;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] result;
  logic        done;
  logic        busy;

  modport master (
    output start,
    output dataa,
    input  result,
    input  done,
    input  busy
  );

  modport slave (
    input  start,
    input  dataa,
    output result,
    output done,
    output busy
  );
endinterface

// File: rtl/int2fp.sv
// rtl/int2fp.sv - 32-bit signed integer to IEEE-754 single, one normalising shift per clock
// INT2FP_ROUND_EN defined: round-to-nearest-even; undefined: truncate the mantissa.
module int2fp (
  input  logic      clk,
  input  logic      reset_n,
  int2fp_if.slave   bus
);

  typedef enum logic {
    IDLE = 1'b0,
    NORM = 1'b1
  } state_t;

  localparam logic [7:0] EXP_TOP = 8'd158;

  state_t      state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [7:0]  exp_q, exp_d;
  logic        sign_q, sign_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;

  logic [22:0] mant_pack;
  logic [7:0]  exp_pack;

`ifdef INT2FP_ROUND_EN
  logic        round_inc;
  logic [23:0] mant_sum;

  // A carry out of the rounded mantissa means the value hit the next power of two.
  always_comb begin
    round_inc = mag_q[7] & ((|mag_q[6:0]) | mag_q[8]);
    mant_sum  = {1'b0, mag_q[30:8]} + {23'd0, round_inc};
    if (mant_sum[23]) begin
      mant_pack = 23'd0;
      exp_pack  = exp_q + 8'd1;
    end else begin
      mant_pack = mant_sum[22:0];
      exp_pack  = exp_q;
    end
  end
`else
  always_comb begin
    mant_pack = mag_q[30:8];
    exp_pack  = exp_q;
  end
`endif

  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.dataa == 32'd0) begin
            result_d = 32'd0;
            done_d   = 1'b1;
          end else begin
            // Negating 0x80000000 wraps to itself, which is the correct magnitude.
            sign_d  = bus.dataa[31];
            mag_d   = bus.dataa[31] ? (~bus.dataa + 32'd1) : bus.dataa;
            exp_d   = EXP_TOP;
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (!mag_q[31]) begin
          mag_d = {mag_q[30:0], 1'b0};
          exp_d = exp_q - 8'd1;
        end else begin
          result_d = {sign_q, exp_pack, mant_pack};
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      mag_q    <= 32'd0;
      exp_q    <= 8'd0;
      sign_q   <= 1'b0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;
  assign bus.busy   = (state_q == NORM);

endmodule

// File: doc/int2fp.md
INT2FP -- requirements
Module: int2fp

Interface
REQ-001 Parameters: none; the block is fixed at 32-bit signed integer in, IEEE-754 single out.
REQ-002 clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 reset_n  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 start  in  1  request; sampled only while busy=0.
REQ-005 dataa  in  32  two's-complement signed integer operand, captured with accepted start.
REQ-006 result  out  32  IEEE-754 single-precision encoding of last converted operand; held until next done.
REQ-007 done  out  1  one-cycle pulse marking result valid.
REQ-008 busy  out  1  high while a conversion is in progress; start ignored while high.

Function
REQ-009 States: IDLE and NORM; busy=1 exactly in NORM.
REQ-010 IDLE, start=1, dataa=0: result<=0x00000000, done<=1 on that edge, stay IDLE (latency 1).
REQ-011 IDLE, start=1, dataa!=0: capture sign=dataa[31], mag=|dataa| as 32-bit unsigned (0x80000000 -> mag 0x80000000), exp<=158, go NORM.
REQ-012 NORM, mag[31]=0: mag<<=1, exp<=exp-1, one bit per clock.
REQ-013 NORM, mag[31]=1: pack result={sign, exp, mantissa}, done<=1, go IDLE on that edge.
REQ-014 Latency: for L leading zeros of mag, done is high L+1 clocks after the start edge (range 1..32); zero operand latency 1.
REQ-015 Mantissa = mag[30:8]; guard=mag[7], sticky=OR(mag[6:0]), lsb=mag[8]; rounding per REQ-022.
REQ-016 Mantissa carry-out from rounding: mantissa<=0, exp<=exp+1 (max exp 158, no overflow possible).
REQ-017 start asserted while busy=1 is dropped, not queued; dataa changes during NORM have no effect.
REQ-018 start in the same cycle done is high (state IDLE) is accepted normally (back-to-back conversions).
REQ-019 done is 0 in every cycle other than those in REQ-010/REQ-013; result changes only on done edges.
REQ-020 Negative zero is never produced.

Reset
REQ-021 reset_n=0 on a rising edge: state<=IDLE, result<=0x00000000, done<=0, busy<=0, internal mag/exp/sign<=0; an in-flight conversion is abandoned with no done pulse; reset dominates start.

Configuration
REQ-022 Macro INT2FP_ROUND_EN: defined -> round-to-nearest-even (increment when guard & (sticky | lsb)); undefined -> truncation (mantissa=mag[30:8], guard/sticky ignored, REQ-016 unreachable). Latency identical in both builds.

Verification
REQ-023 Reset mid-NORM: dataa=0x00000001 start, assert reset_n=0 at cycle 10 -> no done pulse, result=0x00000000, busy=0 next cycle.
REQ-024 dataa=0x00000001 -> done exactly 32 clocks after start edge, result=0x3F800000; dataa=0xFFFFFFFD (-3) -> 0xC0400000 after 31 clocks.
REQ-025 dataa=0x80000000 -> result=0xCF000000, done 1 clock after start; dataa=0 -> 0x00000000, latency 1.
REQ-026 With INT2FP_ROUND_EN: 0x7FFFFFFF -> 0x4F000000; 0x01000001 -> 0x4B800000 (tie to even); 0x01000003 -> 0x4B800002. Without it: 0x7FFFFFFF -> 0x4EFFFFFF; 0x01000003 -> 0x4B800001.
REQ-027 start pulsed every cycle during a conversion of 0x00000001 -> exactly one done per accepted start; extra starts ignored; start held through done edge begins next conversion immediately.
REQ-028 Cross-check: feed result pairs of dataa=5 and dataa=-7 to the team's float comparator -> geq=1, leq=0.
